// File: rtl/dvs_ravens_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dvs_ravens_pkg : shared RAVENS packet types and constants
// Rev 1.0
// ----------------------------------------------------------------------------
package dvs_ravens_pkg;

  localparam int RAVENS_PKT_BITS      = 32;
  localparam int RAVENS_BYTES_PER_PKT = RAVENS_PKT_BITS / 8;

  typedef logic [RAVENS_PKT_BITS-1:0] ravens_pkt_t;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/ravens_pkt_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ravens_pkt_fifo : synchronous first-word fall-through FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module ravens_pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ravens_pkt_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ravens_pkt_tx : captures changed RAVENS packets, buffers and serialises them
// Rev 1.0
// ----------------------------------------------------------------------------
module ravens_pkt_tx
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int DROP_CNT_BITS = 16,
  parameter int PKT_BITS      = RAVENS_PKT_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PKT_BITS-1:0]           ravens_pkt,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [DROP_CNT_BITS-1:0]      drop_count
);

  localparam int BYTES = PKT_BITS / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

  ser_state_e               state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [PKT_BITS-1:0]      shift_q, shift_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [PKT_BITS-1:0]      prev_q;
  logic                     overflow_q;
  logic [DROP_CNT_BITS-1:0] drop_cnt_q;

  logic                new_pkt, pop, drop;
  logic                fifo_full, fifo_empty;
  logic [PKT_BITS-1:0] fifo_dout;

  assign new_pkt = (ravens_pkt != prev_q);
  // pop is only ever raised with the FIFO non-empty, so it is an effective pop.
  assign drop    = new_pkt && fifo_full && !pop;

  ravens_pkt_fifo #(
    .WIDTH (PKT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (new_pkt),
    .pop   (pop),
    .din   (ravens_pkt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = fifo_dout[PKT_BITS-1 -: 8];
          shift_d    = fifo_dout << 8;
          state_d    = SER_SEND;
        end
      end
      SER_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = shift_q[PKT_BITS-1 -: 8];
            shift_d   = shift_q << 8;
          end else if (!fifo_empty) begin
            // Chain straight into the next packet without an idle bubble.
            pop       = 1'b1;
            idx_d     = '0;
            tx_data_d = fifo_dout[PKT_BITS-1 -: 8];
            shift_d   = fifo_dout << 8;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = SER_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SER_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      if (new_pkt) prev_q <= ravens_pkt;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ravens_pkt_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ravens_pkt_tx : directed and stalled-stream bench for ravens_pkt_tx
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ravens_pkt_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] ravens_pkt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  ravens_pkt_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ravens_pkt (ravens_pkt),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc;
  int          nb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Records the byte accepted at the coming edge, then advances to the next negedge.
  task automatic cyc();
    if (tx_valid && tx_ready) begin
      acc = {acc[23:0], tx_data};
      nb++;
      if (nb == 4) begin
        rx_q.push_back(acc);
        nb = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    nb  = 0;
    acc = '0;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          bad;
    int          n;
    logic [31:0] cur, v;

    rst_n      = 1'b0;
    ravens_pkt = '0;
    tx_ready   = 1'b0;
    rx_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);

    // Single spike: byte order and latency
    ravens_pkt = 32'h0000_0B60;
    tx_ready   = 1'b1;
    cyc();
    check("t1_level_k", fifo_level, 1);
    check("t1_valid_k", tx_valid, 0);
    cyc();
    check("t1_valid_b0", tx_valid, 1);
    check("t1_b0", tx_data, 8'h00);
    check("t1_level_b0", fifo_level, 0);
    cyc();
    check("t1_b1", tx_data, 8'h00);
    cyc();
    check("t1_b2", tx_data, 8'h0B);
    cyc();
    check("t1_b3", tx_data, 8'h60);
    check("t1_valid_b3", tx_valid, 1);
    cyc();
    check("t1_valid_end", tx_valid, 0);
    check("t1_npkt", rx_q.size(), 1);
    check("t1_pkt", rx_at(0), 32'h0000_0B60);

    // Backpressure on byte 0
    rx_clear();
    tx_ready   = 1'b0;
    ravens_pkt = 32'h1234_5678;
    cyc();
    cyc();
    check("t2_b0", tx_data, 8'h12);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!tx_valid || tx_data !== 8'h12) bad++;
    end
    check("t2_stable", bad, 0);
    tx_ready = 1'b1;
    repeat (10) cyc();
    check("t2_npkt", rx_q.size(), 1);
    check("t2_pkt", rx_at(0), 32'h1234_5678);

    // Overflow: 18 packets into a stalled link
    rx_clear();
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ravens_pkt = 32'hA000_0000 + 32'(i);
      cyc();
    end
    cyc();
    check("t3_level", fifo_level, 16);
    check("t3_ovf", overflow, 1);
    check("t3_drop", drop_count, 1);
    tx_ready = 1'b1;
    repeat (90) cyc();
    check("t3_npkt", rx_q.size(), 17);
    for (int i = 0; i < 17; i++) check($sformatf("t3_pkt%0d", i), rx_at(i), 32'hA000_0000 + 32'(i));

    // Held value is captured once
    rx_clear();
    ravens_pkt = 32'h0000_0B60;
    repeat (50) cyc();
    ravens_pkt = 32'h0000_0B80;
    repeat (20) cyc();
    check("t4_npkt", rx_q.size(), 2);
    check("t4_pkt0", rx_at(0), 32'h0000_0B60);
    check("t4_pkt1", rx_at(1), 32'h0000_0B80);

    // Full FIFO with a pop on the same edge as a new packet
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ravens_pkt = 32'hC000_0000 + 32'(i);
      cyc();
    end
    check("t5_level_full", fifo_level, 16);
    rx_clear();
    tx_ready = 1'b1;
    repeat (3) cyc();
    ravens_pkt = 32'hCF00_00FF;
    cyc();
    tx_ready = 1'b0;
    check("t5_level", fifo_level, 16);
    check("t5_drop", drop_count, 1);
    tx_ready = 1'b1;
    repeat (100) cyc();
    check("t5_npkt", rx_q.size(), 18);
    check("t5_first", rx_at(0), 32'hC000_0000);
    check("t5_last", rx_at(17), 32'hCF00_00FF);

    // Asynchronous reset while byte 2 is on the bus
    ravens_pkt = 32'h1122_3344;
    n = 0;
    while (!(tx_valid && tx_data == 8'h33) && n < 20) begin
      cyc();
      n++;
    end
    check("t6_reached_b2", n < 20, 1);
    #1;
    rst_n      = 1'b0;
    ravens_pkt = '0;
    #1;
    check("t6_valid", tx_valid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ovf", overflow, 0);
    check("t6_drop", drop_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_clear();
    ravens_pkt = 32'h5566_7788;
    repeat (10) cyc();
    check("t6_npkt", rx_q.size(), 1);
    check("t6_pkt", rx_at(0), 32'h5566_7788);

    // Random stalls, 30% of cycles with tx_ready low
    rx_clear();
    cur = 32'h5566_7788;
    for (int p = 0; p < 300; p++) begin
      v = $urandom;
      if (v == cur) v = ~v;
      ravens_pkt = v;
      exp_q.push_back(v);
      cur = v;
      for (int c = 0; c < 8; c++) begin
        tx_ready = ($urandom_range(0, 9) >= 3);
        cyc();
      end
    end
    tx_ready = 1'b1;
    repeat (60) cyc();
    check("rnd_npkt", rx_q.size(), exp_q.size());
    check("rnd_drop", drop_count, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (rx_at(i) !== exp_q[i]) bad++;
    check("rnd_order", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
